teclado_matricial: RTL



---
 rtl/teclado_matricial.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/teclado_matricial.sv
`default_nettype none
// ============================================================================
// Module      : teclado_matricial
// Description : 4x4 keypad scanner/debouncer that packs digits into packets.
// Revision    : 1.0 - initial release
// ============================================================================
module teclado_matricial #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int MAX_DIGITS      = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [3:0]                col_matricial,
  input  logic [3:0]                lin_matricial,
  output logic [MAX_DIGITS*4-1:0]   digitos_value,
  output logic                      digitos_valid,
  output logic                      tecla_pressionada
);

  localparam int c_cw = $clog2(MAX_DIGITS + 1);
  localparam int c_sw = $clog2(SCAN_CYCLES + 1);
  localparam int c_dw = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_sw-1:0] c_scan_last = c_sw'(SCAN_CYCLES - 1);
  localparam logic [c_dw-1:0] c_deb_last  = c_dw'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_tw-1:0] c_timeout   = c_tw'(TIMEOUT_CYCLES);
  localparam logic [c_cw-1:0] c_max       = c_cw'(MAX_DIGITS);
  localparam logic [MAX_DIGITS*4-1:0] c_empty = {MAX_DIGITS{4'hF}};

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_ACCEPT       = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  state_t                   r_state, w_next;
  logic [3:0]               r_lin_meta, r_lin_sync;
  logic [1:0]               r_col_idx, r_row, w_row;
  logic [c_sw-1:0]          r_scan_cnt;
  logic [c_dw-1:0]          r_deb_cnt;
  logic [c_tw-1:0]          r_idle;
  logic [c_cw-1:0]          r_count;
  logic [MAX_DIGITS*4-1:0]  r_buf, r_out;
  logic                     r_valid;
  logic [3:0]               w_key;
  logic                     w_any_low, w_scan_done, w_same_key, w_deb_done, w_rel_done;

  assign col_matricial     = ~(4'b0001 << r_col_idx);
  assign digitos_value     = r_out;
  assign digitos_valid     = r_valid;
  assign tecla_pressionada = (r_state == ST_ACCEPT);

  // Lowest low row index wins when several rows are pulled down.
  always_comb begin
    w_row = 2'd0;
    if      (!r_lin_sync[0]) w_row = 2'd0;
    else if (!r_lin_sync[1]) w_row = 2'd1;
    else if (!r_lin_sync[2]) w_row = 2'd2;
    else if (!r_lin_sync[3]) w_row = 2'd3;
  end

  assign w_any_low   = ~&r_lin_sync;
  assign w_scan_done = (r_scan_cnt == c_scan_last);
  assign w_same_key  = w_any_low && (w_row == r_row);
  assign w_deb_done  = w_same_key && (r_deb_cnt == c_deb_last);
  assign w_rel_done  = (&r_lin_sync) && (r_deb_cnt == c_deb_last);

  always_comb begin
    w_key = 4'hF;
    case ({r_row, r_col_idx})
      4'h0: w_key = 4'h1;  4'h1: w_key = 4'h2;  4'h2: w_key = 4'h3;  4'h3: w_key = 4'hA;
      4'h4: w_key = 4'h4;  4'h5: w_key = 4'h5;  4'h6: w_key = 4'h6;  4'h7: w_key = 4'hB;
      4'h8: w_key = 4'h7;  4'h9: w_key = 4'h8;  4'hA: w_key = 4'h9;  4'hB: w_key = 4'hC;
      4'hC: w_key = 4'hE;  4'hD: w_key = 4'h0;  4'hE: w_key = 4'hF;  default: w_key = 4'hD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SCAN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SCAN:         if (w_scan_done && w_any_low) w_next = ST_DEBOUNCE;
      ST_DEBOUNCE:     if (!w_same_key) w_next = ST_SCAN;
                       else if (w_deb_done) w_next = ST_ACCEPT;
      ST_ACCEPT:       w_next = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: if (w_rel_done) w_next = ST_SCAN;
      default:         w_next = ST_SCAN;
    endcase
  end

  // Scan/debounce counters; the column only advances on a quiet scan or after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lin_meta <= 4'hF;
      r_lin_sync <= 4'hF;
      r_col_idx  <= 2'd0;
      r_row      <= 2'd0;
      r_scan_cnt <= '0;
      r_deb_cnt  <= '0;
    end else begin
      r_lin_meta <= lin_matricial;
      r_lin_sync <= r_lin_meta;
      case (r_state)
        ST_SCAN: begin
          if (w_scan_done) begin
            r_scan_cnt <= '0;
            if (w_any_low) begin
              r_row     <= w_row;
              r_deb_cnt <= c_dw'(1);
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + c_sw'(1);
          end
        end
        ST_DEBOUNCE: r_deb_cnt <= w_same_key ? r_deb_cnt + c_dw'(1) : '0;
        ST_ACCEPT:   r_deb_cnt <= '0;
        default: begin
          if (!(&r_lin_sync)) begin
            r_deb_cnt <= '0;
          end else if (w_rel_done) begin
            r_deb_cnt <= '0;
            r_col_idx <= r_col_idx + 2'd1;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_dw'(1);
          end
        end
      endcase
    end
  end

  // Key actions, packet emission and idle timeout; ACCEPT takes priority over timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= c_empty;
      r_out   <= c_empty;
      r_count <= '0;
      r_idle  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == ST_ACCEPT) begin
        r_idle <= '0;
        if (w_key <= 4'd9) begin
          if (r_count < c_max) begin
            r_buf   <= {r_buf[MAX_DIGITS*4-5:0], w_key};
            r_count <= r_count + c_cw'(1);
          end
        end else if (w_key == 4'hF) begin
          if (r_count != '0) begin
            r_out   <= r_buf;
            r_valid <= 1'b1;
            r_buf   <= c_empty;
            r_count <= '0;
          end
        end else if (w_key == 4'hE) begin
          r_buf   <= c_empty;
          r_count <= '0;
        end else begin
          r_out   <= {c_empty[MAX_DIGITS*4-1:4], w_key};
          r_valid <= 1'b1;
        end
      end else if (r_idle != c_timeout) begin
        r_idle <= r_idle + c_tw'(1);
      end else if (r_count != '0) begin
        r_buf   <= c_empty;
        r_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire
